// File: rtl/ctrl_program_loader_pkg.sv
// ctrl_loader_pkg: shared types and constants for the control-program loader.
//   - loader_state_t : loader FSM states (encoding fixed, visible to debug tools)
//   - ADDR_WIDTH_D / CTRL_WIDTH_D : default BRAM address and control-word widths
//   - term_misplaced : terminator placement check for one readback word
package ctrl_loader_pkg;

    localparam int ADDR_WIDTH_D = 10;
    localparam int CTRL_WIDTH_D = 60;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LOADED = 3'd2,
        ST_VERIFY = 3'd3,
        ST_ERROR  = 3'd4
    } loader_state_t;

    // A word is badly terminated when its completion bit disagrees with
    // whether it is the last word of the program.
    function automatic logic term_misplaced(input logic i_last, input logic i_bit0);
        return i_last ^ i_bit0;
    endfunction

endpackage

// File: rtl/ctrl_program_loader_if.sv
// ctrl_program_loader_if: control-word stream and control-BRAM port bundle.
//   S_DATA/S_VALID/S_READY : incoming control-word stream
//   bram_addr/din/en/we    : BRAM write/read request
//   bram_dout              : BRAM read data (1-cycle latency)
// master = loader side, slave = data source + BRAM side.
interface ctrl_program_loader_if #(
    parameter int ADDR_WIDTH = ctrl_loader_pkg::ADDR_WIDTH_D,
    parameter int CTRL_WIDTH = ctrl_loader_pkg::CTRL_WIDTH_D
);
    logic [CTRL_WIDTH-1:0] S_DATA;
    logic                  S_VALID;
    logic                  S_READY;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [CTRL_WIDTH-1:0] bram_din;
    logic [CTRL_WIDTH-1:0] bram_dout;
    logic                  bram_en;
    logic                  bram_we;

    modport master (
        input  S_DATA, S_VALID, bram_dout,
        output S_READY, bram_addr, bram_din, bram_en, bram_we
    );

    modport slave (
        output S_DATA, S_VALID, bram_dout,
        input  S_READY, bram_addr, bram_din, bram_en, bram_we
    );
endinterface

// File: rtl/ctrl_program_loader_checksum.sv
// ctrl_checksum: XOR accumulator.
//   clk/rst : clock, async active-high reset
//   i_clr   : synchronous clear (wins over i_en)
//   i_en    : fold i_data into the sum
//   o_sum   : running XOR of all folded words since the last clear
module ctrl_checksum #(
    parameter int WIDTH = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] r_sum;

    // Running XOR with clear priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_sum <= {WIDTH{1'b0}};
        end else if (i_en) begin
            r_sum <= r_sum ^ i_data;
        end else begin
            r_sum <= r_sum;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/myReg.sv
// myReg: generic enabled register with asynchronous active-high clear.
//   clk  : clock          ARST : async clear
//   i_en : load enable    i_d  : next value    o_q : stored value
module myReg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             ARST,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Storage element: cleared by ARST, loaded when enabled
    always_ff @(posedge clk or posedge ARST) begin
        if (ARST) begin
            o_q <= {WIDTH{1'b0}};
        end else if (i_en) begin
            o_q <= i_d;
        end else begin
            o_q <= o_q;
        end
    end

endmodule

// File: rtl/ctrl_program_loader.sv
// ctrl_program_loader: writes a stream of control words into the control BRAM
// at consecutive addresses, keeps an XOR checksum, and can read the program
// back to confirm contents and terminator placement.
//   CLK_100, RST                    : clock, async active-high reset
//   LOAD_START / VERIFY_START       : level inputs, rising edge starts load / readback
//   ABORT                           : synchronous return to IDLE
//   bus (master)                    : control-word stream + BRAM port
//   WORD_COUNT                      : words written in the current load
//   LOADED / OVERFLOW               : load finished with terminator / BRAM filled without one
//   VERIFY_DONE / VERIFY_OK / BUSY  : readback status, LOAD or VERIFY active
module ctrl_program_loader
    import ctrl_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int CTRL_WIDTH = CTRL_WIDTH_D
) (
    input  logic                  CLK_100,
    input  logic                  RST,
    input  logic                  LOAD_START,
    input  logic                  VERIFY_START,
    input  logic                  ABORT,
    ctrl_program_loader_if.master bus,
    output logic [ADDR_WIDTH:0]   WORD_COUNT,
    output logic                  LOADED,
    output logic                  OVERFLOW,
    output logic                  VERIFY_DONE,
    output logic                  VERIFY_OK,
    output logic                  BUSY
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    loader_state_t r_state, w_next;

    logic                  r_load_start_d, r_verify_start_d;
    logic                  r_rd_vld, r_term_err;
    logic                  r_loaded, r_overflow, r_verify_done, r_verify_ok;
    logic                  w_load_rise, w_verify_rise;
    logic                  w_accept, w_wr, w_rd_issue, w_rd_last, w_term_bad;
    logic                  w_cnt_clr, w_rd_clr;
    logic                  w_clr_load, w_clr_verify, w_set_loaded, w_set_ovf, w_verify_end;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH:0]   w_word_cnt, w_rd_cnt;
    logic [CTRL_WIDTH-1:0] w_load_sum, w_rd_sum, w_rd_final;

    assign w_load_rise   = LOAD_START & ~r_load_start_d;
    assign w_verify_rise = VERIFY_START & ~r_verify_start_d;

    // The handshake completes whenever LOAD holds and data is valid; ABORT
    // only blocks the write and the bookkeeping, not the handshake itself.
    assign w_accept   = (r_state == ST_LOAD) & bus.S_VALID;
    assign w_wr       = w_accept & ~ABORT;
    assign w_rd_issue = (r_state == ST_VERIFY) & (w_rd_cnt < w_word_cnt) & ~ABORT;
    // The read counter runs one ahead of the tagged word, so the tagged word
    // is the last one when every read has already been issued.
    assign w_rd_last  = r_rd_vld & (w_rd_cnt == w_word_cnt);
    assign w_term_bad = r_rd_vld & term_misplaced(w_rd_last, bus.bram_dout[0]);
    // The last word is compared before it lands in the accumulator so that
    // VERIFY_DONE/OK can be registered in the same cycle.
    assign w_rd_final = w_rd_sum ^ bus.bram_dout;

    assign w_cnt_clr = w_clr_load | ABORT;
    assign w_rd_clr  = w_clr_verify | ABORT;

    // Start-input history for rising-edge detection
    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            r_load_start_d   <= 1'b0;
            r_verify_start_d <= 1'b0;
        end else begin
            r_load_start_d   <= LOAD_START;
            r_verify_start_d <= VERIFY_START;
        end
    end

    // FSM state register
    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and one-cycle event strobes
    always_comb begin
        w_next       = r_state;
        w_clr_load   = 1'b0;
        w_clr_verify = 1'b0;
        w_set_loaded = 1'b0;
        w_set_ovf    = 1'b0;
        w_verify_end = 1'b0;
        if (ABORT) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_rise) begin
                        w_next     = ST_LOAD;
                        w_clr_load = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (w_accept & bus.S_DATA[0]) begin
                        w_next       = ST_LOADED;
                        w_set_loaded = 1'b1;
                    end else if (w_accept & (w_addr == LAST_ADDR)) begin
                        w_next    = ST_ERROR;
                        w_set_ovf = 1'b1;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end
                ST_LOADED: begin
                    if (w_load_rise) begin
                        w_next     = ST_LOAD;
                        w_clr_load = 1'b1;
                    end else if (w_verify_rise) begin
                        w_next       = ST_VERIFY;
                        w_clr_verify = 1'b1;
                    end else begin
                        w_next = ST_LOADED;
                    end
                end
                ST_VERIFY: begin
                    if (w_rd_last) begin
                        w_next       = ST_LOADED;
                        w_verify_end = 1'b1;
                    end else begin
                        w_next = ST_VERIFY;
                    end
                end
                ST_ERROR: begin
                    w_next = ST_ERROR;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    // BRAM port and stream handshake; writes go out in the accept cycle
    always_comb begin
        bus.S_READY   = (r_state == ST_LOAD);
        bus.bram_en   = w_accept | w_rd_issue;
        bus.bram_we   = w_wr;
        bus.bram_din  = bus.S_DATA;
        if (r_state == ST_VERIFY) begin
            bus.bram_addr = w_rd_cnt[ADDR_WIDTH-1:0];
        end else begin
            bus.bram_addr = w_addr;
        end
    end

    myReg #(.WIDTH(ADDR_WIDTH)) u_addr_cnt (
        .clk  (CLK_100),
        .ARST (RST),
        .i_en (w_cnt_clr | w_wr),
        .i_d  (w_cnt_clr ? {ADDR_WIDTH{1'b0}} : (w_addr + ADDR_ONE)),
        .o_q  (w_addr)
    );

    myReg #(.WIDTH(ADDR_WIDTH+1)) u_word_cnt (
        .clk  (CLK_100),
        .ARST (RST),
        .i_en (w_cnt_clr | w_wr),
        .i_d  (w_cnt_clr ? {(ADDR_WIDTH+1){1'b0}} : (w_word_cnt + CNT_ONE)),
        .o_q  (w_word_cnt)
    );

    myReg #(.WIDTH(ADDR_WIDTH+1)) u_rd_cnt (
        .clk  (CLK_100),
        .ARST (RST),
        .i_en (w_rd_clr | w_rd_issue),
        .i_d  (w_rd_clr ? {(ADDR_WIDTH+1){1'b0}} : (w_rd_cnt + CNT_ONE)),
        .o_q  (w_rd_cnt)
    );

    ctrl_checksum #(.WIDTH(CTRL_WIDTH)) u_load_sum (
        .clk    (CLK_100),
        .rst    (RST),
        .i_clr  (w_cnt_clr),
        .i_en   (w_wr),
        .i_data (bus.S_DATA),
        .o_sum  (w_load_sum)
    );

    ctrl_checksum #(.WIDTH(CTRL_WIDTH)) u_rd_sum (
        .clk    (CLK_100),
        .rst    (RST),
        .i_clr  (w_rd_clr),
        .i_en   (r_rd_vld & ~ABORT),
        .i_data (bus.bram_dout),
        .o_sum  (w_rd_sum)
    );

    // Readback valid tag and sticky terminator-error flag
    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            r_rd_vld   <= 1'b0;
            r_term_err <= 1'b0;
        end else if (ABORT) begin
            r_rd_vld   <= 1'b0;
            r_term_err <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_issue;
            if (w_clr_verify) begin
                r_term_err <= 1'b0;
            end else if (w_term_bad) begin
                r_term_err <= 1'b1;
            end else begin
                r_term_err <= r_term_err;
            end
        end
    end

    // Status flags, all set or cleared by FSM events
    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            r_loaded      <= 1'b0;
            r_overflow    <= 1'b0;
            r_verify_done <= 1'b0;
            r_verify_ok   <= 1'b0;
        end else if (ABORT | w_clr_load) begin
            r_loaded      <= 1'b0;
            r_overflow    <= 1'b0;
            r_verify_done <= 1'b0;
            r_verify_ok   <= 1'b0;
        end else if (w_set_loaded) begin
            r_loaded <= 1'b1;
        end else if (w_set_ovf) begin
            r_overflow <= 1'b1;
        end else if (w_clr_verify) begin
            r_verify_done <= 1'b0;
            r_verify_ok   <= 1'b0;
        end else if (w_verify_end) begin
            r_verify_done <= 1'b1;
            r_verify_ok   <= (w_load_sum == w_rd_final) & ~(r_term_err | w_term_bad);
        end else begin
            r_loaded      <= r_loaded;
            r_overflow    <= r_overflow;
            r_verify_done <= r_verify_done;
            r_verify_ok   <= r_verify_ok;
        end
    end

    assign WORD_COUNT  = w_word_cnt;
    assign LOADED      = r_loaded;
    assign OVERFLOW    = r_overflow;
    assign VERIFY_DONE = r_verify_done;
    assign VERIFY_OK   = r_verify_ok;
    assign BUSY        = (r_state == ST_LOAD) | (r_state == ST_VERIFY);

endmodule
